// File: rtl/yutorina_loader_pkg.sv
// ============================================================================
// yutorina_loader_pkg : shared types and constants for the SPM boot loader
// Rev 1.0
// ============================================================================
`default_nettype none

package yutorina_loader_pkg;

  localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
  localparam int         HDR_LEN        = 3;
  localparam int         WORD_W         = 32;
  localparam int         BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN_H = 3'd1,
    S_LEN_L = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/yutorina_spm_loader_if.sv
// ============================================================================
// yutorina_spm_loader_if : byte stream in, SPM write port and CPU control out
// Rev 1.0
// ============================================================================
`default_nettype none

interface yutorina_spm_loader_if
  import yutorina_loader_pkg::*;
#(
  parameter int SPM_ADDR_W = 12
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [SPM_ADDR_W-1:0] spm_addr;
  logic [WORD_W-1:0]     spm_wr_data;
  logic                  spm_we;
  logic                  cpu_reset;
  logic                  load_done;
  logic                  load_error;

  // master: byte source and SPM/CPU observer; slave: the loader itself
  modport master (
    output rx_data, rx_valid,
    input  spm_addr, spm_wr_data, spm_we, cpu_reset, load_done, load_error
  );

  modport slave (
    input  rx_data, rx_valid,
    output spm_addr, spm_wr_data, spm_we, cpu_reset, load_done, load_error
  );

endinterface

`default_nettype wire

// File: rtl/yutorina_loader_word_asm.sv
// ============================================================================
// yutorina_loader_word_asm : big-endian byte-to-word assembler with XOR sum
// Rev 1.0
// ============================================================================
`default_nettype none

module yutorina_loader_word_asm
  import yutorina_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_ready,
  output logic [7:0]        csum,
  output logic              last_byte
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] byte_idx;

  assign last_byte = (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word       <= '0;
      word_ready <= 1'b0;
      csum       <= '0;
      byte_idx   <= '0;
    end else begin
      // word stays stable through the ready cycle; the next byte lands after it
      word_ready <= byte_valid && last_byte && !clear;
      if (clear) begin
        byte_idx <= '0;
        csum     <= '0;
      end else if (byte_valid) begin
        word     <= {word[WORD_W-9:0], byte_data};
        byte_idx <= byte_idx + 1'b1;
        csum     <= csum ^ byte_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/yutorina_spm_loader.sv
// ============================================================================
// yutorina_spm_loader : framed, checksummed boot image loader into the SPM.
// Optional inter-byte timeout enabled by YUTORINA_LOADER_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module yutorina_spm_loader
  import yutorina_loader_pkg::*;
#(
  parameter int         SPM_ADDR_W     = 12,
  parameter logic [7:0] MAGIC          = MAGIC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  yutorina_spm_loader_if.slave  bus
);

  localparam int IDX_W = SPM_ADDR_W + 1;

  state_t            state;
  logic [7:0]        len_h;
  logic [15:0]       len;
  logic [IDX_W-1:0]  word_idx;
  logic              cpu_rst_q;
  logic              done_q;
  logic              err_q;

  logic [WORD_W-1:0] asm_word;
  logic              asm_ready;
  logic [7:0]        asm_csum;
  logic              asm_last;
  logic              timeout_hit;

  wire         rx_fire   = bus.rx_valid;
  wire [15:0]  len_next  = {len_h, bus.rx_data};
  wire         asm_clear = rx_fire && (state == S_LEN_L);
  wire         byte_fire = rx_fire && (state == S_DATA);
  // 17-bit compares keep N = 2^SPM_ADDR_W legal without wrapping the index
  wire         len_bad   = 17'(len_next) > (17'd1 << SPM_ADDR_W);
  wire         last_word = (17'(word_idx) + 17'd1) == {1'b0, len};

  yutorina_loader_word_asm u_word_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (byte_fire),
    .byte_data  (bus.rx_data),
    .word       (asm_word),
    .word_ready (asm_ready),
    .csum       (asm_csum),
    .last_byte  (asm_last)
  );

`ifdef YUTORINA_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] idle_cnt;
  wire waiting = (state == S_LEN_H) || (state == S_LEN_L) ||
                 (state == S_DATA)  || (state == S_CSUM);

  assign timeout_hit = waiting && !rx_fire && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (!waiting || rx_fire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      len_h     <= '0;
      len       <= '0;
      word_idx  <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (asm_ready) begin
        word_idx <= word_idx + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (rx_fire && bus.rx_data == MAGIC) state <= S_LEN_H;
        end
        S_LEN_H: begin
          if (rx_fire) begin
            len_h <= bus.rx_data;
            state <= S_LEN_L;
          end
        end
        S_LEN_L: begin
          if (rx_fire) begin
            len      <= len_next;
            word_idx <= '0;
            if (len_next == 16'd0) begin
              state <= S_CSUM;
            end else if (len_bad) begin
              state <= S_ERROR;
              err_q <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // leave on the final byte so a back-to-back CSUM byte is not missed
          if (byte_fire && asm_last && last_word) state <= S_CSUM;
        end
        S_CSUM: begin
          if (rx_fire) begin
            if (bus.rx_data == asm_csum) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state <= S_ERROR;
              err_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          cpu_rst_q <= 1'b0;
        end
        S_ERROR: begin
          if (rx_fire && bus.rx_data == MAGIC) begin
            err_q <= 1'b0;
            state <= S_LEN_H;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (timeout_hit) begin
        state <= S_ERROR;
        err_q <= 1'b1;
      end
    end
  end

  assign bus.spm_addr    = word_idx[SPM_ADDR_W-1:0];
  assign bus.spm_wr_data = asm_word;
  assign bus.spm_we      = asm_ready;
  assign bus.cpu_reset   = cpu_rst_q;
  assign bus.load_done   = done_q;
  assign bus.load_error  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_yutorina_spm_loader.sv
// ============================================================================
// tb_yutorina_spm_loader : directed frames, write scoreboard, status checks
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_yutorina_spm_loader;

  localparam int         AW   = 12;
  localparam logic [7:0] MGC  = 8'hA5;
`ifdef YUTORINA_LOADER_TIMEOUT_EN
  localparam logic       EXP_TIMEOUT_ERR = 1'b1;
`else
  localparam logic       EXP_TIMEOUT_ERR = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   n_writes = 0;
  logic prev_we  = 1'b0;
  wr_t  exp_q[$];

  always #5 clock = ~clock;

  yutorina_spm_loader_if #(.SPM_ADDR_W(AW)) bus ();

  yutorina_spm_loader #(
    .SPM_ADDR_W     (AW),
    .MAGIC          (MGC),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Write monitor: every SPM write must match the head of the expected queue
  always @(negedge clock) begin
    if (bus.spm_we === 1'b1) begin
      n_writes++;
      check("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spm_write_unexpected: got addr %h data %h expected none",
                 bus.spm_addr, bus.spm_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("spm_addr", 32'(bus.spm_addr), 32'(e.addr));
        check("spm_wr_data", bus.spm_wr_data, e.data);
      end
    end
    prev_we = (bus.spm_we === 1'b1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic hard_reset();
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic push_words(input logic [31:0] words[$], input int count);
    for (int i = 0; i < count; i++) begin
      exp_q.push_back('{addr: AW'(i), data: words[i]});
    end
  endtask

  // Sends a full frame; returns just after the edge that sampled the checksum byte
  task automatic send_image(input logic [31:0] words[$], input int gap, input logic corrupt);
    logic [7:0]  cs;
    logic [15:0] n;
    logic [31:0] w;
    cs = 8'h00;
    n  = 16'(words.size());
    push_words(words, words.size());
    send_byte(MGC);      idle(gap);
    send_byte(n[15:8]);  idle(gap);
    send_byte(n[7:0]);   idle(gap);
    foreach (words[i]) begin
      w = words[i];
      for (int b = 3; b >= 0; b--) begin
        cs ^= w[b*8 +: 8];
        send_byte(w[b*8 +: 8]);
        idle(gap);
      end
    end
    send_byte(corrupt ? (cs ^ 8'h01) : cs);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_spm_addr"},    32'(bus.spm_addr), 32'd0);
    check({tag, "_spm_wr_data"}, bus.spm_wr_data, 32'd0);
    check({tag, "_spm_we"},      32'(bus.spm_we), 32'd0);
    check({tag, "_cpu_reset"},   32'(bus.cpu_reset), 32'd1);
    check({tag, "_load_done"},   32'(bus.load_done), 32'd0);
    check({tag, "_load_error"},  32'(bus.load_error), 32'd0);
  endtask

  initial begin
    logic [31:0] img_a[$];
    logic [31:0] img_b[$];
    logic [31:0] empty_img[$];
    int base;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    img_a = '{32'hDEADBEEF, 32'h01234567};
    img_b = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};

    idle(3);
    check_reset_outputs("por");
    reset = 1'b0;
    idle(1);

    // Good two-word image, spaced bytes
    base = n_writes;
    send_image(img_a, 1, 1'b0);
    check("a_load_done", 32'(bus.load_done), 32'd1);
    check("a_cpu_reset_entry", 32'(bus.cpu_reset), 32'd1);
    idle(1);
    check("a_cpu_reset_released", 32'(bus.cpu_reset), 32'd0);
    check("a_load_error", 32'(bus.load_error), 32'd0);
    send_byte(MGC);
    idle(2);
    check("a_write_count", 32'(n_writes - base), 32'd2);
    check("a_done_terminal", 32'(bus.load_done), 32'd1);

    // Corrupt checksum, then recovery with the correct frame
    hard_reset();
    base = n_writes;
    send_image(img_a, 0, 1'b1);
    check("bad_load_error", 32'(bus.load_error), 32'd1);
    check("bad_load_done", 32'(bus.load_done), 32'd0);
    idle(3);
    check("bad_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    send_image(img_a, 0, 1'b0);
    check("retry_load_done", 32'(bus.load_done), 32'd1);
    check("retry_load_error", 32'(bus.load_error), 32'd0);
    idle(2);
    check("retry_write_count", 32'(n_writes - base), 32'd4);

    // Garbage before an empty image
    hard_reset();
    base = n_writes;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    check("garbage_ignored", 32'(bus.load_error), 32'd0);
    send_image(empty_img, 0, 1'b0);
    check("empty_load_done", 32'(bus.load_done), 32'd1);
    idle(2);
    check("empty_write_count", 32'(n_writes - base), 32'd0);

    // Oversize length 0x1001
    hard_reset();
    base = n_writes;
    send_byte(MGC);
    send_byte(8'h10);
    send_byte(8'h01);
    check("oversize_load_error", 32'(bus.load_error), 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(4);
    check("oversize_write_count", 32'(n_writes - base), 32'd0);
    check("oversize_cpu_reset", 32'(bus.cpu_reset), 32'd1);

    // Back-to-back four-word image
    hard_reset();
    base = n_writes;
    send_image(img_b, 0, 1'b0);
    check("b2b_load_done", 32'(bus.load_done), 32'd1);
    idle(2);
    check("b2b_write_count", 32'(n_writes - base), 32'd4);

    // Asynchronous reset in the middle of word 2 of a second frame
    hard_reset();
    base = n_writes;
    push_words(img_b, 2);
    send_byte(MGC);
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 0; i < 10; i++) begin
      send_byte(img_b[i / 4][(3 - (i % 4)) * 8 +: 8]);
    end
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    idle(1);
    reset = 1'b0;
    idle(2);
    check("midreset_write_count", 32'(n_writes - base), 32'd2);

    // Stall in LEN_L for 60 cycles
    hard_reset();
    send_byte(MGC);
    send_byte(8'h00);
    idle(60);
    check("stall_load_error", 32'(bus.load_error), 32'(EXP_TIMEOUT_ERR));
    check("stall_load_done", 32'(bus.load_done), 32'd0);

    idle(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
